// File: rtl/clk_edge_monitor.sv
// Watches a divided clock from another domain: synchronizes it, emits edge strobes,
// measures the rise-to-rise period and tracks frequency lock through a small FSM.
module clk_edge_monitor #(
  parameter int EXP_PERIOD = 20,
  parameter int TOL        = 2,
  parameter int LOCK_CNT   = 4,
  parameter int TIMEOUT    = 40
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        slow_clk_in,
  input  logic        en,
  output logic        rise_stb,
  output logic        fall_stb,
  output logic        locked,
  output logic        lost,
  output logic [7:0]  period,
  output logic [15:0] edge_cnt
);

  localparam logic [7:0] PER_LO    = 8'(EXP_PERIOD - TOL);
  localparam logic [7:0] PER_HI    = 8'(EXP_PERIOD + TOL);
  localparam logic [7:0] LOCK_C    = 8'(LOCK_CNT);
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        sync1_q, sync2_q, sync3_q;
  logic        rise_stb_q, fall_stb_q;
  logic [7:0]  per_cnt_q, per_cnt_d;
  logic [7:0]  period_q, period_d;
  logic        have_ref_q, have_ref_d;
  logic [7:0]  good_cnt_q, good_cnt_d;
  logic [15:0] edge_cnt_q, edge_cnt_d;
  logic        locked_q, lost_q;

  logic        rise_s, fall_s, good_s, timeout_s;
  logic [7:0]  good_inc_s;

  assign rise_s     = sync2_q & ~sync3_q;
  assign fall_s     = ~sync2_q & sync3_q;
  // per_cnt_q still holds the just-finished period in the cycle a rise is seen
  assign good_s     = (per_cnt_q >= PER_LO) && (per_cnt_q <= PER_HI);
  assign timeout_s  = ~rise_s && (per_cnt_q >= TIMEOUT_C);
  assign good_inc_s = good_cnt_q + 8'd1;

  always_comb begin
    per_cnt_d = per_cnt_q;
    period_d  = period_q;
    if (rise_s) begin
      per_cnt_d = 8'd1;
      period_d  = per_cnt_q;
    end else if (per_cnt_q != 8'hFF) begin
      per_cnt_d = per_cnt_q + 8'd1;
    end else begin
      per_cnt_d = per_cnt_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    have_ref_d = have_ref_q;
    good_cnt_d = good_cnt_q;
    edge_cnt_d = edge_cnt_q;
    if (!en) begin
      // disable wins over everything, including a rise in the same cycle
      state_d = IDLE;
    end else begin
      if (rise_s && (state_q != IDLE)) begin
        edge_cnt_d = edge_cnt_q + 16'd1;
      end else begin
        edge_cnt_d = edge_cnt_q;
      end
      case (state_q)
        IDLE: begin
          state_d    = ACQUIRE;
          have_ref_d = 1'b0;
          good_cnt_d = 8'd0;
          edge_cnt_d = 16'd0;
        end
        ACQUIRE: begin
          if (rise_s) begin
            if (!have_ref_q) begin
              have_ref_d = 1'b1;
            end else if (good_s) begin
              good_cnt_d = good_inc_s;
              if (good_inc_s >= LOCK_C) begin
                state_d = LOCKED;
              end else begin
                state_d = ACQUIRE;
              end
            end else begin
              good_cnt_d = 8'd0;
            end
          end else if (timeout_s) begin
            good_cnt_d = 8'd0;
            have_ref_d = 1'b0;
          end else begin
            state_d = ACQUIRE;
          end
        end
        LOCKED: begin
          if ((rise_s && !good_s) || timeout_s) begin
            state_d = LOST;
          end else begin
            state_d = LOCKED;
          end
        end
        LOST: begin
          state_d = LOST;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
      rise_stb_q <= 1'b0;
      fall_stb_q <= 1'b0;
      per_cnt_q  <= 8'd0;
      period_q   <= 8'd0;
      state_q    <= IDLE;
      have_ref_q <= 1'b0;
      good_cnt_q <= 8'd0;
      edge_cnt_q <= 16'd0;
      locked_q   <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      sync1_q    <= slow_clk_in;
      sync2_q    <= sync1_q;
      sync3_q    <= sync2_q;
      rise_stb_q <= rise_s;
      fall_stb_q <= fall_s;
      per_cnt_q  <= per_cnt_d;
      period_q   <= period_d;
      state_q    <= state_d;
      have_ref_q <= have_ref_d;
      good_cnt_q <= good_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      locked_q   <= (state_d == LOCKED);
      lost_q     <= (state_d == LOST);
    end
  end

  assign rise_stb = rise_stb_q;
  assign fall_stb = fall_stb_q;
  assign locked   = locked_q;
  assign lost     = lost_q;
  assign period   = period_q;
  assign edge_cnt = edge_cnt_q;

endmodule

// File: tb/tb_clk_edge_monitor.sv
// Scoreboard bench: each generated slow-clock rise queues its expected strobe-time
// outputs; a negedge monitor pops and compares whenever rise_stb appears.
module tb_clk_edge_monitor;

  logic        clk_in = 1'b0;
  logic        rst_n = 1'b0;
  logic        slow_clk_in = 1'b0;
  logic        en = 1'b0;
  logic        rise_stb, fall_stb, locked, lost;
  logic [7:0]  period;
  logic [15:0] edge_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rise_cyc = 0;
  int exp_fall_gap = 0;
  bit clk_run = 1'b1;

  typedef struct packed {
    logic        chk_per;
    logic [7:0]  per;
    logic        lk;
    logic        ls;
    logic [15:0] ec;
  } exp_t;

  exp_t sb_q[$];

  clk_edge_monitor dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .slow_clk_in (slow_clk_in),
    .en          (en),
    .rise_stb    (rise_stb),
    .fall_stb    (fall_stb),
    .locked      (locked),
    .lost        (lost),
    .period      (period),
    .edge_cnt    (edge_cnt)
  );

  initial forever begin
    #5;
    if (clk_run) clk_in = ~clk_in;
  end

  always @(posedge clk_in) cyc++;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Monitor: pops one expectation per rise strobe, times falls against the last rise
  always @(negedge clk_in) begin
    exp_t e;
    if (rst_n) begin
      if (rise_stb || fall_stb) chk("stb_overlap", int'(rise_stb & fall_stb), 0);
      if (rise_stb) begin
        last_rise_cyc = cyc;
        chk("rise_expected", int'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          if (e.chk_per) chk("period", int'(period), int'(e.per));
          chk("locked_at_rise", int'(locked), int'(e.lk));
          chk("lost_at_rise", int'(lost), int'(e.ls));
          chk("edge_cnt", int'(edge_cnt), int'(e.ec));
        end
      end
      if (fall_stb && exp_fall_gap != 0) chk("fall_gap", cyc - last_rise_cyc, exp_fall_gap);
    end
  end

  // n slow periods of hi/lo cycles; lock expected from the lock_at-th rise on
  task automatic gen(input int n, input int hi, input int lo, input int ec0,
                     input int lock_at, input bit ls);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.chk_per = (i != 0);
      e.per     = 8'(hi + lo);
      e.lk      = (lock_at != 0) && (i + 1 >= lock_at);
      e.ls      = ls;
      e.ec      = 16'(ec0 + i);
      sb_q.push_back(e);
      slow_clk_in = 1'b1;
      repeat (hi) @(negedge clk_in);
      slow_clk_in = 1'b0;
      repeat (lo) @(negedge clk_in);
    end
  endtask

  task automatic push_one(input int per, input bit lk, input bit ls, input int ec);
    exp_t e;
    e.chk_per = 1'b1;
    e.per     = 8'(per);
    e.lk      = lk;
    e.ls      = ls;
    e.ec      = 16'(ec);
    sb_q.push_back(e);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rise_stb"}, int'(rise_stb), 0);
    chk({tag, "_fall_stb"}, int'(fall_stb), 0);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_lost"}, int'(lost), 0);
    chk({tag, "_period"}, int'(period), 0);
    chk({tag, "_edge_cnt"}, int'(edge_cnt), 0);
  endtask

  initial begin
    int k;
    #1;
    chk_all_zero("rst");
    repeat (3) @(negedge clk_in);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_in);

    // 10/10 slow clock: lock on the 5th rise
    en = 1'b1;
    repeat (2) @(negedge clk_in);
    exp_fall_gap = 10;
    gen(8, 10, 10, 1, 5, 1'b0);

    // clock stops while locked: lost exactly 40 cycles after the last rise strobe
    k = 0;
    while (!lost && k < 100) begin
      @(negedge clk_in);
      k++;
    end
    chk("lost_after_stop", int'(lost), 1);
    chk("locked_after_stop", int'(locked), 0);
    chk("lost_delay", cyc - last_rise_cyc, 40);

    // LOST holds even when good edges come back
    gen(3, 10, 10, 9, 0, 1'b1);
    chk("lost_hold", int'(lost), 1);
    en = 1'b0;
    @(negedge clk_in);
    chk("idle_locked", int'(locked), 0);
    chk("idle_lost", int'(lost), 0);

    // period 22: upper bound still good
    en = 1'b1;
    repeat (2) @(negedge clk_in);
    exp_fall_gap = 11;
    gen(6, 11, 11, 1, 5, 1'b0);

    // period 23: never locks
    en = 1'b0;
    @(negedge clk_in);
    en = 1'b1;
    repeat (2) @(negedge clk_in);
    exp_fall_gap = 12;
    gen(7, 12, 11, 1, 0, 1'b0);
    chk("p23_locked", int'(locked), 0);

    // lock again, then drop en on the very edge that registers a rise
    en = 1'b0;
    @(negedge clk_in);
    en = 1'b1;
    repeat (2) @(negedge clk_in);
    exp_fall_gap = 10;
    gen(6, 10, 10, 1, 5, 1'b0);
    push_one(20, 1'b0, 1'b0, 6);
    slow_clk_in = 1'b1;
    repeat (2) @(negedge clk_in);
    en = 1'b0;
    repeat (8) @(negedge clk_in);
    slow_clk_in = 1'b0;
    repeat (10) @(negedge clk_in);
    chk("endrop_edge_cnt", int'(edge_cnt), 6);
    chk("endrop_locked", int'(locked), 0);

    // async reset mid-period with clk_in stopped
    en = 1'b1;
    repeat (2) @(negedge clk_in);
    gen(5, 10, 10, 1, 5, 1'b0);
    push_one(20, 1'b1, 1'b0, 6);
    slow_clk_in = 1'b1;
    repeat (5) @(negedge clk_in);
    chk("pre_rst_locked", int'(locked), 1);
    clk_run = 1'b0;
    #7;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    slow_clk_in = 1'b0;
    #5;
    rst_n = 1'b1;
    #5;
    clk_run = 1'b1;
    repeat (5) @(negedge clk_in);
    chk("post_rst_locked", int'(locked), 0);
    chk("post_rst_edge_cnt", int'(edge_cnt), 0);
    chk("sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_edge_monitor.md
CLK_EDGE_MONITOR -- requirements
Module: clk_edge_monitor

Interface
REQ-001 SHALL have parameter EXP_PERIOD, default 20: expected slow-clock period in clk_in cycles.
REQ-002 SHALL have parameter TOL, default 2: allowed ± deviation of the measured period from EXP_PERIOD.
REQ-003 SHALL have parameter LOCK_CNT, default 4: number of consecutive good periods required to lock.
REQ-004 SHALL have parameter TIMEOUT, default 40: per_cnt value that counts as a missing rising edge.
REQ-005 SHALL have port clk_in  input  1  system clock, 100 MHz.
REQ-006 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port slow_clk_in  input  1  divided clock from the clock divider, asynchronous to this block.
REQ-008 SHALL have port en  input  1  monitor enable.
REQ-009 SHALL have port rise_stb  output  1  one-cycle pulse per slow-clock rising edge.
REQ-010 SHALL have port fall_stb  output  1  one-cycle pulse per slow-clock falling edge.
REQ-011 SHALL have port locked  output  1  high while the state is LOCKED.
REQ-012 SHALL have port lost  output  1  high while the state is LOST.
REQ-013 SHALL have port period  output  8  last measured rise-to-rise period, in clk_in cycles.
REQ-014 SHALL have port edge_cnt  output  16  count of rising edges seen while enabled.

Function
REQ-015 SHALL pass slow_clk_in through a 2-flop synchronizer (sync1, sync2) followed by a history flop sync3.
REQ-016 SHALL define rise as sync2 & ~sync3 and fall as ~sync2 & sync3, and SHALL register both onto rise_stb and fall_stb.
REQ-017 SHALL assert rise_stb for exactly one cycle, after the 3rd clk_in edge following a 0->1 change on slow_clk_in (with setup met); fall_stb SHALL follow the same timing for a 1->0 change.
REQ-018 SHALL load per_cnt (8 bit) with 1 on a rise and otherwise increment it, saturating at 255; on a rise, period SHALL load the old per_cnt, so a 20-cycle input gives period=20.
REQ-019 SHALL treat a measured period as good when EXP_PERIOD-TOL <= period <= EXP_PERIOD+TOL, both bounds inclusive.
REQ-020 SHALL implement FSM states IDLE, ACQUIRE, LOCKED and LOST.
REQ-021 IDLE: when en=1, SHALL go to ACQUIRE and clear have_ref, good_cnt and edge_cnt.
REQ-022 ACQUIRE: the first rise SHALL only set have_ref and SHALL not be judged.
REQ-023 ACQUIRE: each later good period SHALL increment good_cnt and each bad period SHALL clear it; reaching LOCK_CNT SHALL go to LOCKED.
REQ-024 ACQUIRE: per_cnt reaching TIMEOUT SHALL clear good_cnt and have_ref.
REQ-025 LOCKED: a bad period, or per_cnt reaching TIMEOUT with no rise, SHALL go to LOST.
REQ-026 LOST: SHALL hold until en=0; re-lock SHALL only occur through IDLE.
REQ-027 en=0 in any state SHALL go to IDLE on the next edge; en=0 has priority over every other event in the same cycle, and a simultaneous rise is not counted.
REQ-028 edge_cnt SHALL increment on every rise while the state is not IDLE, wrapping from 0xFFFF to 0.
REQ-029 rise_stb, fall_stb and period SHALL update regardless of en.
REQ-030 locked and lost SHALL be registered state decodes, mutually exclusive.

Reset
REQ-031 rst_n=0 SHALL asynchronously clear sync1..sync3, per_cnt, period, good_cnt, have_ref, edge_cnt and all outputs to 0, and SHALL set the state to IDLE.
REQ-032 Release of rst_n SHALL be synchronous to clk_in; the first rise after reset SHALL be judged only once have_ref is set.

Verification
REQ-033 Bench SHALL check: 10-high/10-low slow clock with en=1 -> rise_stb every 20 cycles, period=20, locked=1 after the 5th rise following en.
REQ-034 Bench SHALL check: slow clock stopped while LOCKED -> lost=1 and locked=0 when per_cnt reaches 40 (about 40 cycles after the last rise).
REQ-035 Bench SHALL check: period 22 -> locks; period 23 -> never locks, good_cnt stays 0.
REQ-036 Bench SHALL check: en dropped while LOCKED, in the same cycle as a rise -> IDLE next cycle, locked=0, lost=0, edge_cnt not incremented.
REQ-037 Bench SHALL check: rst_n pulsed low mid-period with clk_in stopped -> all outputs 0 immediately.
REQ-038 Bench SHALL check: 10/10 input -> fall_stb a single cycle, exactly 10 cycles after each rise_stb, never overlapping it.
